rv32_wb_arbiter: RTL and testbench
==================================

# rv32_wb_arbiter

Two-port Wishbone B4 classic bus arbiter and sequencer for the RV32 core. It shares one Wishbone master port between the memory stage's data port (peripheral region 0x2xxx_xxxx loads/stores) and the fetch unit's instruction port. It runs each granted request as a single CYC/STB cycle and returns read data or an error with a one-cycle done pulse. A bus timeout protects the pipeline from unresponsive slaves.

## Interface
- TIMEOUT_CYCLES, 255: BUS-state cycles without ACK/ERR before a forced error; legal range 1..65535.
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- d_req_i  in  1  data-port request level; held with stable d_* fields until d_done_o.
- d_we_i  in  1  data write (1) / read (0).
- d_sel_i  in  4  byte lane select.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  store data, already lane-aligned.
- d_rdata_o  out  32  load data, valid while d_done_o.
- d_done_o  out  1  one-cycle completion pulse.
- d_err_o  out  1  completion with bus error or timeout; only with d_done_o.
- i_req_i, i_addr_i[31:0]  in  instruction-port request and address; reads only, sel forced to 4'hF.
- i_rdata_o[31:0], i_done_o, i_err_o  out  same meaning as the data-port outputs.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control, registered.
- wb_sel_o  out  4; wb_adr_o, wb_dat_o  out  32: registered.
- wb_dat_i  in  32; wb_ack_i, wb_err_i  in  1: slave response.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the grant, address, sel, we and wdata into registers, assert wb_cyc_o and wb_stb_o, go to BUS.
- Arbitration is round-robin on simultaneous requests: the port not granted last wins. A single requester always wins. The last_grant register resets to instruction, so data wins the first tie.
- BUS:
  - wb_* outputs hold stable.
  - wb_err_i: go to DONE with err=1 and rdata=0. Err wins over a simultaneous ack.
  - wb_ack_i: go to DONE with rdata = wb_dat_i on reads, 0 on writes.
  - Timeout counter reaches TIMEOUT_CYCLES: go to DONE with err=1.
  - On leaving BUS: drop cyc/stb/we on the same edge and zero the timeout counter.
- DONE:
  - Pulse the granted port's done (and err if set) for exactly one cycle, with rdata driven.
  - Requests are ignored in DONE; return to IDLE.
  - The requester deasserts or changes req in the cycle after done.
- Ungranted port outputs are 0. Neither done pulse fires unless that port was granted.
- Requests that drop during BUS are not aborted; the transaction completes and done still pulses.

## Timing
- Reset values: every output 0; FSM in IDLE; counter 0; last_grant = instruction.
- Async reset mid-transaction drops wb_cyc_o immediately and loses the transaction, with no done pulse.
- Latency, request seen in IDLE at edge N:
  - cyc/stb high from N+1.
  - ACK sampled at edge M moves the FSM to DONE, with done high during cycle M+1.
  - IDLE again at M+2.
- A zero-wait slave (ack combinational with stb) gives a 3-cycle request-to-idle transaction.
- Throughput: one transaction per 3 cycles minimum; one dead IDLE cycle after each DONE.
- Timeout counter:
  - 16 bits; increments each BUS cycle without ack/err.
  - Err is taken at the edge where count == TIMEOUT_CYCLES-1 with no ack, so BUS lasts exactly TIMEOUT_CYCLES cycles.
  - The counter never wraps.

## Structure
- Package rv32_wb_pkg holds:
  - state enum {IDLE, BUS, DONE};
  - grant enum {GRANT_D, GRANT_I};
  - the constant WB_SEL_WORD = 4'hF;
  - the default timeout constant.
- Sub-module rv32_wb_timeout holds the counter, with clear/enable inputs and an expire output.

## Test plan
- Data read only: d_req at edge 0, addr 0x2000_0004, slave acks 2 cycles after stb with 0xDEADBEEF -> wb_adr_o=0x2000_0004, we=0, sel=0xF in cycles 1-3; d_done_o=1 and d_rdata_o=0xDEADBEEF in cycle 4; i_done_o stays 0.
- Simultaneous d_req and i_req, held, zero-wait slave -> grants in order D, I, D, I; each done 3 cycles apart; wb_adr_o alternates between the two addresses.
- Write with sel=4'b0011 and wdata 0x0000_ABCD -> wb_we_o=1, sel 0x3, dat 0x0000_ABCD held stable until ack; d_rdata_o=0 at done.
- Slave asserts wb_ack_i and wb_err_i together -> d_err_o=1, d_rdata_o=0, single done pulse.
- TIMEOUT_CYCLES=4, no slave response -> cyc high for exactly 4 cycles, then i_done_o=1 and i_err_o=1; next request proceeds normally.
- rst_n_i pulsed low mid-BUS -> wb_cyc_o drops asynchronously, no done pulse; after release, a tie grants the data port first.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// Shared types and constants for the RV32 Wishbone arbiter/sequencer.
package rv32_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_D = 1'b0,
    GRANT_I = 1'b1
  } grant_e;

  localparam logic [3:0]  WB_SEL_WORD     = 4'hF;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rv32_wb_timeout.sv
// Bus-cycle watchdog: counts BUS cycles without a slave response and flags
// the cycle in which the limit is reached. Saturates instead of wrapping.
module rv32_wb_timeout
  import rv32_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign expire = en && (count == LAST_COUNT);

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic master between the
// data and instruction ports; one single-beat CYC/STB cycle per grant.
//   state | meaning
//   IDLE  | waiting for a request; latches the winner onto the bus
//   BUS   | cyc/stb held until ack, err or timeout
//   DONE  | one-cycle done pulse to the granted port
module rv32_wb_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_done_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_done_o,
  output logic        i_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  state_e      state;
  grant_e      grant_q;
  grant_e      last_grant;
  grant_e      next_grant;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        to_expire;
  logic        bus_exit;
  logic        d_active;
  logic        i_active;

  always_comb begin
    next_grant = GRANT_I;
    if (d_req_i && (!i_req_i || (last_grant == GRANT_I))) begin
      next_grant = GRANT_D;
    end
  end

  assign bus_exit = (state == BUS) && (wb_ack_i || wb_err_i || to_expire);

  rv32_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr    ((state != BUS) || bus_exit),
    .en     ((state == BUS) && !wb_ack_i && !wb_err_i),
    .expire (to_expire)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      grant_q    <= GRANT_D;
      last_grant <= GRANT_I;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req_i || i_req_i) begin
            grant_q    <= next_grant;
            last_grant <= next_grant;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            if (next_grant == GRANT_D) begin
              wb_we_o  <= d_we_i;
              wb_sel_o <= d_sel_i;
              wb_adr_o <= d_addr_i;
              wb_dat_o <= d_wdata_i;
            end else begin
              wb_we_o  <= 1'b0;
              wb_sel_o <= WB_SEL_WORD;
              wb_adr_o <= i_addr_i;
              wb_dat_o <= '0;
            end
            state <= BUS;
          end
        end
        BUS: begin
          if (bus_exit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            // Without ack, leaving BUS means err or timeout; err beats ack.
            err_q    <= wb_err_i || !wb_ack_i;
            rdata_q  <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign d_active  = (state == DONE) && (grant_q == GRANT_D);
  assign i_active  = (state == DONE) && (grant_q == GRANT_I);
  assign d_done_o  = d_active;
  assign d_err_o   = d_active && err_q;
  assign d_rdata_o = d_active ? rdata_q : '0;
  assign i_done_o  = i_active;
  assign i_err_o   = i_active && err_q;
  assign i_rdata_o = i_active ? rdata_q : '0;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Scoreboard bench for rv32_wb_arbiter: directed stimulus pushes expected
// completions; a negedge monitor pops and compares every done pulse.
module tb_rv32_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        d_done_o, d_err_o;
  logic        i_req_i;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        i_done_o, i_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  logic        slv_ack_en, slv_err_en;
  logic [7:0]  slv_delay, wcnt;
  logic [31:0] slv_data;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_cnt = 0;
  int   n, hi, prev_done;
  bit   seen;
  logic [31:0] tie_adr[4];

  always #5 clk_i = ~clk_i;

  rv32_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_err_o(d_err_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
    .i_done_o(i_done_o), .i_err_o(i_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Slave model: responds slv_delay cycles after stb rises (0 = same cycle).
  assign wb_ack_i = wb_cyc_o && wb_stb_o && slv_ack_en && (wcnt == slv_delay);
  assign wb_err_i = wb_cyc_o && wb_stb_o && slv_err_en && (wcnt == slv_delay);
  assign wb_dat_i = slv_data;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wcnt <= '0;
    else if (!(wb_cyc_o && wb_stb_o)) wcnt <= '0;
    else if (!wb_ack_i && !wb_err_i) wcnt <= wcnt + 8'd1;
  end

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d;
    e.err = err;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n_i && (d_done_o || i_done_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got d_done=%0b i_done=%0b expected none", d_done_o, i_done_o);
      end else begin
        e = exp_q.pop_front();
        check("done_resp",
              {28'd0, d_done_o, i_done_o, d_err_o, i_err_o, d_rdata_o, i_rdata_o},
              {28'd0, e.is_d, !e.is_d, e.is_d & e.err, !e.is_d & e.err,
               e.is_d ? e.rdata : 32'd0, e.is_d ? 32'd0 : e.rdata});
      end
    end
  end

  task automatic wait_done(input string name, output int cnt);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (d_done_o || i_done_o) begin
        cnt = k;
        break;
      end
    end
    if (cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic wait_cyc(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (wb_cyc_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got cyc=0 expected cyc=1 within 20 cycles", name);
    end
  endtask

  task automatic next_edge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    d_req_i = 0; d_we_i = 0; d_sel_i = 0; d_addr_i = 0; d_wdata_i = 0;
    i_req_i = 0; i_addr_i = 0;
    slv_ack_en = 0; slv_err_en = 0; slv_delay = 0; slv_data = 0;

    #12;
    check("reset_wb", {21'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 96'd0);
    check("reset_port", {28'd0, d_done_o, d_err_o, i_done_o, i_err_o, d_rdata_o, i_rdata_o}, 96'd0);
    #10 rst_n_i = 1'b1;
    next_edge();

    // Tie with held requests and a zero-wait slave: D, I, D, I.
    slv_ack_en = 1; slv_delay = 0; slv_data = 32'h1234_5678;
    tie_adr[0] = 32'h2000_0010; tie_adr[1] = 32'h0000_0100;
    tie_adr[2] = 32'h2000_0010; tie_adr[3] = 32'h0000_0100;
    for (int k = 0; k < 4; k++) push(k % 2 == 0, 0, 32'h1234_5678);
    d_req_i = 1; d_we_i = 0; d_sel_i = 4'hF; d_addr_i = 32'h2000_0010;
    i_req_i = 1; i_addr_i = 32'h0000_0100;
    prev_done = 0;
    for (int k = 0; k < 4; k++) begin
      wait_cyc("tie_cyc");
      check("tie_adr", {64'd0, wb_adr_o}, {64'd0, tie_adr[k]});
      wait_done("tie_done", n);
      if (k > 0) check("tie_spacing", 96'(cyc_cnt - prev_done), 96'd3);
      prev_done = cyc_cnt;
    end
    next_edge();
    d_req_i = 0; i_req_i = 0;
    next_edge();

    // Data read, ack two cycles after stb.
    slv_delay = 2; slv_data = 32'hDEAD_BEEF;
    push(1, 0, 32'hDEAD_BEEF);
    d_req_i = 1; d_we_i = 0; d_sel_i = 4'hF; d_addr_i = 32'h2000_0004;
    @(posedge clk_i);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      check("rd_bus", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, 32'd0},
            {27'd0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h2000_0004, 32'd0});
    end
    wait_done("rd_done", n);
    check("rd_latency", 96'(n), 96'd1);
    next_edge();
    d_req_i = 0;
    next_edge();

    // Partial-word write: bus fields stable until ack, rdata zero at done.
    push(1, 0, 32'd0);
    d_req_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_addr_i = 32'h2000_0020;
    d_wdata_i = 32'h0000_ABCD;
    @(posedge clk_i);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      check("wr_bus", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
            {27'd0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h2000_0020, 32'h0000_ABCD});
    end
    wait_done("wr_done", n);
    check("wr_latency", 96'(n), 96'd1);
    next_edge();
    d_req_i = 0; d_we_i = 0; d_wdata_i = 0;
    next_edge();

    // Ack and err together: err wins, rdata zeroed.
    slv_err_en = 1; slv_delay = 1;
    push(1, 1, 32'd0);
    d_req_i = 1; d_sel_i = 4'hF; d_addr_i = 32'h2000_0008;
    wait_done("ackerr_done", n);
    next_edge();
    d_req_i = 0;
    next_edge();
    check("ackerr_cyc_dropped", {95'd0, wb_cyc_o}, 96'd0);

    // No slave response: timeout after exactly 4 BUS cycles.
    slv_ack_en = 0; slv_err_en = 0;
    push(0, 1, 32'd0);
    i_req_i = 1; i_addr_i = 32'h0000_0200;
    hi = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (wb_cyc_o) hi++;
      if (i_done_o) begin
        seen = 1;
        break;
      end
    end
    check("timeout_seen", {95'd0, seen}, 96'd1);
    check("timeout_cyc_cycles", 96'(hi), 96'd4);
    next_edge();
    i_req_i = 0;
    next_edge();

    slv_ack_en = 1; slv_delay = 0; slv_data = 32'h0BAD_F00D;
    push(0, 0, 32'h0BAD_F00D);
    i_req_i = 1; i_addr_i = 32'h0000_0204;
    wait_cyc("after_to_cyc");
    check("after_to_adr", {64'd0, wb_adr_o}, {64'd0, 32'h0000_0204});
    wait_done("after_to_done", n);
    next_edge();
    i_req_i = 0;
    next_edge();

    // Async reset mid-BUS: cyc drops at once and no done follows.
    slv_ack_en = 0;
    d_req_i = 1; d_addr_i = 32'h2000_0030;
    wait_cyc("rst_cyc");
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("rst_async_drop", {94'd0, wb_cyc_o, wb_stb_o}, 96'd0);
    d_req_i = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("rst_no_pending", 96'(exp_q.size()), 96'd0);

    slv_ack_en = 1; slv_delay = 0; slv_data = 32'hCAFE_0001;
    push(1, 0, 32'hCAFE_0001);
    next_edge();
    d_req_i = 1; d_addr_i = 32'h2000_0040;
    i_req_i = 1; i_addr_i = 32'h0000_0300;
    wait_cyc("rst_tie_cyc");
    check("rst_tie_adr", {64'd0, wb_adr_o}, {64'd0, 32'h2000_0040});
    wait_done("rst_tie_done", n);
    next_edge();
    d_req_i = 0; i_req_i = 0;
    repeat (5) @(negedge clk_i);
    check("final_queue_empty", 96'(exp_q.size()), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
